pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction word width.
REQ-002 SHALL have parameter CTRL_W, default 12, per-stage control bundle width.
REQ-003 SHALL have parameter STAGES, default 3, pipeline depth (>=2); stage 0 youngest, STAGES-1 oldest.
REQ-004 SHALL have parameter SQUASH, default 2, bubbles injected after a taken branch (0..7).
REQ-005 SHALL have parameter BUBBLE_CTRL, default 12'h029, control value carried by invalid stages.
REQ-006 SHALL have parameter WE_BIT, default 2, index of register-write-enable in control bundle.
REQ-007 SHALL have port Clock, input, 1, the single clock; all state on rising edge.
REQ-008 SHALL have port Reset, input, 1, synchronous, active-high.
REQ-009 SHALL have ports in_instr (INSTR_W), in_ctrl (CTRL_W), in_valid (1), inputs, the fetched instruction entering stage 0.
REQ-010 SHALL have port stall_req, input, 1, freezes all stages.
REQ-011 SHALL have port branch_taken, input, 1, taken branch resolved in stage STAGES-1.
REQ-012 SHALL have ports stage_instr (STAGES*INSTR_W), stage_ctrl (STAGES*CTRL_W), stage_valid (STAGES), outputs; slice k is stage k.
REQ-013 SHALL have port pc_advance, output, 1, fetch may move to next PC.
REQ-014 SHALL have ports fwd_a, fwd_b, outputs, $clog2(STAGES) bits each, forwarding source for stage-0 operands.
REQ-015 SHALL have ports retired_cnt, bubble_cnt, outputs, 16 bits each.

Function
REQ-016 SHALL advance (stage k -> k+1, input -> stage 0) on each edge where advance = !stall_req.
REQ-017 SHALL hold every stage register, counter and squash count unchanged while stall_req=1; branch_taken ignored during stall.
REQ-018 SHALL load stage 0 with in_instr/in_ctrl and valid=in_valid when advancing with squash count 0.
REQ-019 SHALL load stage 0 with instr 0, ctrl BUBBLE_CTRL, valid 0 when advancing with squash count >0, then decrement squash count by 1.
REQ-020 SHALL, on advance with branch_taken=1 and stage_valid[STAGES-1]=1, clear valid in all stages (instr 0, ctrl BUBBLE_CTRL) and load squash count with SQUASH; branch_taken with oldest stage invalid SHALL be ignored.
REQ-021 SHALL treat branch flush as overriding REQ-018/019 for that edge (stage 0 gets a bubble, counts toward no squash).
REQ-022 SHALL drive pc_advance = !stall_req & (squash count == 0) combinationally.
REQ-023 SHALL force stage_ctrl slice to BUBBLE_CTRL whenever its valid=0.
REQ-024 SHALL compute fwd_a: rs1 = stage0 instr[9:5]; value = smallest k>=1 with stage k valid, ctrl[WE_BIT]=1, instr[4:0]==rs1, rs1!=31; 0 if none or stage 0 invalid.
REQ-025 SHALL compute fwd_b identically with rs2 = stage0 instr[20:16].
REQ-026 SHALL increment retired_cnt on advance when stage_valid[STAGES-1]=1 (the instruction leaving), wrapping 16'hFFFF -> 0.
REQ-027 SHALL increment bubble_cnt on advance when stage 0 is loaded invalid for any reason, wrapping at 16 bits.
REQ-028 SHALL have zero-cycle combinational paths only for pc_advance, fwd_a, fwd_b; all other outputs registered.

Reset
REQ-029 SHALL, on Reset=1 at a rising edge, set all stage_valid 0, stage_instr 0, stage_ctrl BUBBLE_CTRL, squash count 0, retired_cnt 0, bubble_cnt 0.
REQ-030 SHALL give Reset priority over stall_req and branch_taken, including mid-squash.
REQ-031 SHALL accept new valid input on the first edge after Reset deasserts.

Verification
REQ-032 Reset, then 5 valid instrs, no stall -> stage_valid 3'b111 after 3 edges; retired_cnt=2 after 5 edges.
REQ-033 stall_req=1 for 4 cycles mid-stream -> all stages, counters frozen; pc_advance=0; resumes unchanged.
REQ-034 branch_taken with oldest valid, SQUASH=2 -> stage_valid 0 next edge; pc_advance=0 for 2 advances; bubble_cnt +3.
REQ-035 stage0 rs1=3, stage1 and stage2 both write x3 -> fwd_a=1; stage1 write to x31 only -> fwd_a=0.
REQ-036 Reset asserted mid-squash with stall_req=1 -> all state reset values next edge, pc_advance=1.
REQ-037 retired_cnt preset via 65535 retirements -> wraps to 0 on next retirement.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - fetch, control and status bundle for pipeline_sequencer
interface pipeline_sequencer_if #(
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 12,
  parameter int STAGES  = 3
);
  localparam int FWD_W = $clog2(STAGES);

  logic [INSTR_W-1:0]        in_instr;
  logic [CTRL_W-1:0]         in_ctrl;
  logic                      in_valid;
  logic                      stall_req;
  logic                      branch_taken;
  logic [STAGES*INSTR_W-1:0] stage_instr;
  logic [STAGES*CTRL_W-1:0]  stage_ctrl;
  logic [STAGES-1:0]         stage_valid;
  logic                      pc_advance;
  logic [FWD_W-1:0]          fwd_a;
  logic [FWD_W-1:0]          fwd_b;
  logic [15:0]               retired_cnt;
  logic [15:0]               bubble_cnt;

  modport master (
    output in_instr, in_ctrl, in_valid, stall_req, branch_taken,
    input  stage_instr, stage_ctrl, stage_valid, pc_advance,
           fwd_a, fwd_b, retired_cnt, bubble_cnt
  );

  modport slave (
    input  in_instr, in_ctrl, in_valid, stall_req, branch_taken,
    output stage_instr, stage_ctrl, stage_valid, pc_advance,
           fwd_a, fwd_b, retired_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - in-order pipeline stage sequencer with stall, branch squash and forwarding
module pipeline_sequencer #(
  parameter int              INSTR_W     = 32,
  parameter int              CTRL_W      = 12,
  parameter int              STAGES      = 3,
  parameter int              SQUASH      = 2,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = 12'h029,
  parameter int              WE_BIT      = 2
) (
  input logic                 Clock,
  input logic                 Reset,
  pipeline_sequencer_if.slave bus
);
  localparam int FWD_W = $clog2(STAGES);

  logic [INSTR_W-1:0] instr_q [STAGES];
  logic [CTRL_W-1:0]  ctrl_q  [STAGES];
  logic [STAGES-1:0]  valid_q;
  logic [2:0]         squash_q;
  logic [15:0]        retired_q;
  logic [15:0]        bubble_q;

  logic advance;
  logic flush;
  logic load_valid;

  assign advance    = !bus.stall_req;
  assign flush      = advance && bus.branch_taken && valid_q[STAGES-1];
  assign load_valid = !flush && (squash_q == 3'd0) && bus.in_valid;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < STAGES; k++) begin
        instr_q[k] <= '0;
        ctrl_q[k]  <= BUBBLE_CTRL;
      end
      valid_q   <= '0;
      squash_q  <= 3'd0;
      retired_q <= 16'd0;
      bubble_q  <= 16'd0;
    end else if (advance) begin
      if (flush) begin
        for (int k = 0; k < STAGES; k++) begin
          instr_q[k] <= '0;
          ctrl_q[k]  <= BUBBLE_CTRL;
        end
        valid_q  <= '0;
        squash_q <= 3'(SQUASH);
      end else begin
        for (int k = STAGES - 1; k >= 1; k--) begin
          instr_q[k] <= instr_q[k-1];
          ctrl_q[k]  <= ctrl_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
        if (squash_q != 3'd0) begin
          instr_q[0] <= '0;
          ctrl_q[0]  <= BUBBLE_CTRL;
          valid_q[0] <= 1'b0;
          squash_q   <= squash_q - 3'd1;
        end else begin
          // Control is stored pre-masked so an invalid slot always reads as a bubble.
          instr_q[0] <= bus.in_instr;
          ctrl_q[0]  <= bus.in_valid ? bus.in_ctrl : BUBBLE_CTRL;
          valid_q[0] <= bus.in_valid;
        end
      end
      if (valid_q[STAGES-1])
        retired_q <= retired_q + 16'd1;
      if (!load_valid)
        bubble_q <= bubble_q + 16'd1;
    end
  end

  always_comb begin
    bus.stage_instr = '0;
    bus.stage_ctrl  = '0;
    for (int k = 0; k < STAGES; k++) begin
      bus.stage_instr[k*INSTR_W +: INSTR_W] = instr_q[k];
      bus.stage_ctrl[k*CTRL_W +: CTRL_W]    = ctrl_q[k];
    end
  end

  assign bus.stage_valid = valid_q;
  assign bus.retired_cnt = retired_q;
  assign bus.bubble_cnt  = bubble_q;
  assign bus.pc_advance  = !bus.stall_req && (squash_q == 3'd0);

  logic [4:0] rs1;
  logic [4:0] rs2;
  assign rs1 = instr_q[0][9:5];
  assign rs2 = instr_q[0][20:16];

  // Walk oldest to youngest so the youngest matching writer wins.
  always_comb begin
    bus.fwd_a = '0;
    bus.fwd_b = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (valid_q[0] && valid_q[k] && ctrl_q[k][WE_BIT]) begin
        if (rs1 != 5'd31 && instr_q[k][4:0] == rs1)
          bus.fwd_a = FWD_W'(k);
        if (rs2 != 5'd31 && instr_q[k][4:0] == rs2)
          bus.fwd_b = FWD_W'(k);
      end
    end
  end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;
  localparam logic [11:0] BUB  = 12'h029;
  localparam logic [11:0] C_WE = 12'h004;

  logic Clock;
  logic Reset;
  int   n_tests;
  int   n_fail;

  pipeline_sequencer_if #(.INSTR_W(32), .CTRL_W(12), .STAGES(3)) bus ();

  pipeline_sequencer #(
    .INSTR_W(32), .CTRL_W(12), .STAGES(3), .SQUASH(2),
    .BUBBLE_CTRL(12'h029), .WE_BIT(2)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [10:0] tag, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [4:0] rd);
    return {tag, rs2, 6'd0, rs1, rd};
  endfunction

  task automatic feed(input logic [31:0] instr, input logic [11:0] ctrl, input logic v);
    bus.in_instr = instr;
    bus.in_ctrl  = ctrl;
    bus.in_valid = v;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset   = 1'b1;
    bus.stall_req    = 1'b0;
    bus.branch_taken = 1'b0;
    feed(32'd0, 12'd0, 1'b0);

    step();
    check("rst_valid", bus.stage_valid, 3'b000);
    check("rst_instr", bus.stage_instr, 96'd0);
    check("rst_ctrl", bus.stage_ctrl, {BUB, BUB, BUB});
    check("rst_retired", bus.retired_cnt, 16'd0);
    check("rst_bubble", bus.bubble_cnt, 16'd0);
    check("rst_pc_adv", bus.pc_advance, 1'b1);

    Reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      feed(mk(11'(i), 5'd0, 5'd0, 5'(i)), C_WE, 1'b1);
      step();
      if (i == 3) check("fill_valid3", bus.stage_valid, 3'b111);
    end
    check("fill_retired", bus.retired_cnt, 16'd2);
    check("fill_bubble", bus.bubble_cnt, 16'd0);
    check("fill_instr", bus.stage_instr,
          {mk(11'd3, 5'd0, 5'd0, 5'd3), mk(11'd4, 5'd0, 5'd0, 5'd4), mk(11'd5, 5'd0, 5'd0, 5'd5)});
    check("fill_ctrl", bus.stage_ctrl, {C_WE, C_WE, C_WE});

    bus.stall_req = 1'b1;
    feed(mk(11'd99, 5'd0, 5'd0, 5'd9), C_WE, 1'b1);
    #1;
    check("stall_pc_adv", bus.pc_advance, 1'b0);
    repeat (4) step();
    check("stall_instr", bus.stage_instr,
          {mk(11'd3, 5'd0, 5'd0, 5'd3), mk(11'd4, 5'd0, 5'd0, 5'd4), mk(11'd5, 5'd0, 5'd0, 5'd5)});
    check("stall_valid", bus.stage_valid, 3'b111);
    check("stall_retired", bus.retired_cnt, 16'd2);
    check("stall_bubble", bus.bubble_cnt, 16'd0);
    bus.stall_req = 1'b0;
    #1;
    check("unstall_pc_adv", bus.pc_advance, 1'b1);

    feed(mk(11'd10, 5'd0, 5'd0, 5'd3), C_WE, 1'b1); step();
    feed(mk(11'd11, 5'd0, 5'd0, 5'd3), C_WE, 1'b1); step();
    feed(mk(11'd12, 5'd0, 5'd3, 5'd7), C_WE, 1'b1); step();
    check("fwd_a_youngest", bus.fwd_a, 2'd1);
    check("fwd_b_none", bus.fwd_b, 2'd0);
    check("fwd_retired", bus.retired_cnt, 16'd5);

    feed(mk(11'd13, 5'd0, 5'd0, 5'd31), C_WE, 1'b1); step();
    feed(mk(11'd14, 5'd7, 5'd31, 5'd2), C_WE, 1'b1); step();
    check("fwd_a_x31", bus.fwd_a, 2'd0);
    check("fwd_b_stage2", bus.fwd_b, 2'd2);
    check("fwd_retired2", bus.retired_cnt, 16'd7);

    bus.branch_taken = 1'b1;
    feed(mk(11'd15, 5'd0, 5'd0, 5'd1), C_WE, 1'b1);
    step();
    bus.branch_taken = 1'b0;
    check("br_valid", bus.stage_valid, 3'b000);
    check("br_instr", bus.stage_instr, 96'd0);
    check("br_ctrl", bus.stage_ctrl, {BUB, BUB, BUB});
    check("br_retired", bus.retired_cnt, 16'd8);
    check("br_bubble1", bus.bubble_cnt, 16'd1);
    check("br_pc_adv0", bus.pc_advance, 1'b0);
    step();
    check("sq_bubble2", bus.bubble_cnt, 16'd2);
    check("sq_pc_adv1", bus.pc_advance, 1'b0);
    step();
    check("sq_bubble3", bus.bubble_cnt, 16'd3);
    check("sq_pc_adv2", bus.pc_advance, 1'b1);
    check("sq_valid", bus.stage_valid, 3'b000);
    feed(mk(11'd16, 5'd0, 5'd0, 5'd1), C_WE, 1'b1);
    step();
    check("post_sq_valid", bus.stage_valid, 3'b001);
    check("post_sq_bubble", bus.bubble_cnt, 16'd3);

    bus.branch_taken = 1'b1;
    feed(mk(11'd17, 5'd0, 5'd0, 5'd1), C_WE, 1'b1);
    step();
    check("br_ign_valid", bus.stage_valid, 3'b011);
    check("br_ign_bubble", bus.bubble_cnt, 16'd3);
    check("br_ign_pc_adv", bus.pc_advance, 1'b1);
    bus.stall_req = 1'b1;
    step();
    check("br_stall_valid", bus.stage_valid, 3'b011);
    bus.stall_req    = 1'b0;
    bus.branch_taken = 1'b0;
    feed(mk(11'd18, 5'd0, 5'd0, 5'd1), C_WE, 1'b1);
    step();
    check("refill_valid", bus.stage_valid, 3'b111);
    check("refill_retired", bus.retired_cnt, 16'd8);

    bus.branch_taken = 1'b1;
    step();
    bus.branch_taken = 1'b0;
    check("br2_retired", bus.retired_cnt, 16'd9);
    check("br2_bubble", bus.bubble_cnt, 16'd4);
    check("br2_pc_adv", bus.pc_advance, 1'b0);
    Reset = 1'b1;
    bus.stall_req = 1'b1;
    step();
    check("rst_sq_valid", bus.stage_valid, 3'b000);
    check("rst_sq_instr", bus.stage_instr, 96'd0);
    check("rst_sq_ctrl", bus.stage_ctrl, {BUB, BUB, BUB});
    check("rst_sq_retired", bus.retired_cnt, 16'd0);
    check("rst_sq_bubble", bus.bubble_cnt, 16'd0);
    Reset = 1'b0;
    bus.stall_req = 1'b0;
    #1;
    check("rst_sq_pc_adv", bus.pc_advance, 1'b1);
    feed(mk(11'd19, 5'd0, 5'd0, 5'd1), C_WE, 1'b1);
    step();
    check("first_after_rst", bus.stage_valid, 3'b001);
    check("first_bubble", bus.bubble_cnt, 16'd0);

    repeat (65537) step();
    check("wrap_pre", bus.retired_cnt, 16'hFFFF);
    check("wrap_bubble", bus.bubble_cnt, 16'd0);
    step();
    check("wrap_zero", bus.retired_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
